noc_output_arbiter: RTL and testbench
=====================================

// Module: noc_output_arbiter
// PURPOSE
//  Packet-level round-robin arbiter for one router output port. Shares the
//  output among NUM_IN input buffers, holding the grant from head flit to tail.
//  Latches src/dest address fields of the granted head flit for route and debug.
//  Sits between the input buffers and the output link register.
// PARAMETERS
//  NUM_IN   4    number of requesting input ports (2..8)
//  FLIT_W   256  flit width in bits
//  ADDR_W   8    node address width
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               synchronous, active-high reset
//  in_valid     in   NUM_IN          per-input flit valid
//  in_flit      in   NUM_IN*FLIT_W   per-input flit; input i at [i*FLIT_W +: FLIT_W]
//  in_head      in   NUM_IN          per-input head-flit marker
//  in_tail      in   NUM_IN          per-input tail-flit marker
//  in_ready     out  NUM_IN          per-input accept
//  out_valid    out  1               output flit valid
//  out_flit     out  FLIT_W          output flit
//  out_tail     out  1               output tail marker
//  out_ready    in   1               downstream accept
//  grant        out  NUM_IN          one-hot current owner; 0 when idle
//  busy         out  1               1 while a packet holds the port
//  cur_src      out  ADDR_W          src field [247:240] of the granted head flit
//  cur_dest     out  ADDR_W          dest field [239:232] of the granted head flit
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, grant=0, busy=0, cur_src=0, cur_dest=0,
//    rr_ptr=NUM_IN-1, so input 0 has top priority first.
//  - The outputs out_valid, in_ready and out_tail are combinational and are 0
//    whenever grant==0.
//  - FSM state IDLE:
//    - Candidates are the inputs with in_valid & in_head.
//    - Search starts at rr_ptr+1 mod NUM_IN; the first candidate wins.
//    - On the next edge: grant <= onehot(winner), busy <= 1, state <= LOCKED.
//    - On the same edge, cur_src/cur_dest are loaded from the winner's flit.
//    - No flit transfers in IDLE. Arbitration costs 1 cycle per packet.
//    - Any valid flit without in_head in IDLE is ignored, and in_ready stays 0.
//  - FSM state LOCKED (owner g):
//    - out_valid = in_valid[g], out_flit = in_flit[g], out_tail = in_tail[g].
//    - in_ready[g] = out_ready, and in_ready for every other input = 0.
//    - Output latency is 0 (pure mux). A transfer occurs when in_valid[g] & out_ready.
//    - A transfer with in_tail[g]=1 sends the FSM to IDLE on that edge and sets
//      grant<=0, busy<=0, rr_ptr<=g. cur_src/cur_dest hold their values.
//    - A head+tail single-flit packet transfers in 1 cycle and then releases.
//    - in_head seen again on the owner before its tail is treated as body; no re-arbitration.
//    - Stalls (out_ready=0 or in_valid[g]=0) of any length keep the grant.
//    - A new arbitration never overlaps the release cycle, so there is always
//      at least one idle cycle between packets.
//  - Reset mid-packet: aborts immediately and returns to IDLE. The partial packet
//    is not tracked, and the upstream buffer must flush it.
//  - rr_ptr is $clog2(NUM_IN) bits; wrap is explicit modulo NUM_IN, which is not
//    a power of two in general.
// STRUCTURE
//  - Package noc_pkg holds:
//    - FLIT_W, ADDR_W.
//    - SRC_MSB=247, SRC_LSB=240, DEST_MSB=239, DEST_LSB=232.
//    - The state encoding localparams IDLE and LOCKED.
//  - Sub-module rr_arbiter #(N) is combinational: (req, ptr) -> one-hot gnt and
//    an any-request flag. Its rotate-priority logic can be reused by other ports.
//  - Top level holds the FSM, grant/pointer registers, address latch and flit mux.
// TESTING
//  - Reset release, in_valid=0 everywhere -> grant=0, busy=0, out_valid=0,
//    cur_src=cur_dest=0.
//  - Inputs 0 and 2 present head flits together -> grant=4'b0001 after 1 cycle.
//    After input 0's tail, input 2 wins next: grant=4'b0100.
//  - Input 1 sends a 3-flit packet with src=8'h12, dest=8'h34 and out_ready
//    toggling -> 3 transfers in order, in_ready[0,2,3]=0 throughout.
//    cur_src=8'h12 and cur_dest=8'h34 are present from the first LOCKED cycle.
//  - All 4 inputs request continuously with 1-flit packets -> grants rotate
//    0,1,2,3,0 with one IDLE cycle between each.
//  - Input 3 is body-only (no head) while idle -> never granted, in_ready[3]=0.
//  - Reset asserted mid-packet on input 2 -> the next cycle is IDLE with grant=0.
//    The following arbitration favours input 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router constants: flit geometry, address field positions and
// the output-arbiter FSM state type.
package noc_pkg;

  localparam int unsigned FLIT_W   = 256;
  localparam int unsigned ADDR_W   = 8;

  localparam int unsigned SRC_MSB  = 247;
  localparam int unsigned SRC_LSB  = 240;
  localparam int unsigned DEST_MSB = 239;
  localparam int unsigned DEST_LSB = 232;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the request just after ptr
// (modulo N) has highest priority. Returns a one-hot grant and an
// any-request flag. N need not be a power of two.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             any
);

  // Scan from ptr+1 with explicit modulo wrap; first request found wins.
  always_comb begin
    int unsigned idx;
    gnt = '0;
    idx = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/noc_output_arbiter.sv
// Packet-level round-robin arbiter for one router output port. A head flit
// wins the port, which stays locked to that input until its tail transfers.
// The output path is a pure mux of the owner's flit; src/dest of the winning
// head flit are latched at arbitration time.
module noc_output_arbiter #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
  parameter int unsigned ADDR_W = noc_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  input  logic [NUM_IN-1:0]        in_head,
  input  logic [NUM_IN-1:0]        in_tail,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_tail,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        grant,
  output logic                     busy,
  output logic [ADDR_W-1:0]        cur_src,
  output logic [ADDR_W-1:0]        cur_dest
);

  import noc_pkg::*;

  localparam int unsigned PTR_W = $clog2(NUM_IN);

  state_t              state_q, state_d;
  logic [NUM_IN-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   src_q, dest_q;

  logic [NUM_IN-1:0]   cand;
  logic [NUM_IN-1:0]   win_gnt;
  logic                win_any;
  logic [FLIT_W-1:0]   win_flit;
  logic [FLIT_W-1:0]   own_flit;
  logic [PTR_W-1:0]    owner_idx;
  logic                load_addr;
  logic                xfer_last;

  // Only head flits compete; body flits seen while idle are ignored.
  assign cand = in_valid & in_head;

  rr_arbiter #(.N(NUM_IN)) u_rr (
    .req (cand),
    .ptr (rr_ptr_q),
    .gnt (win_gnt),
    .any (win_any)
  );

  // One-hot muxes: winner's flit for the address latch, owner's flit for output.
  always_comb begin
    win_flit  = '0;
    own_flit  = '0;
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (win_gnt[i]) begin
        win_flit = win_flit | in_flit[i*FLIT_W +: FLIT_W];
      end
      if (grant_q[i]) begin
        own_flit  = own_flit | in_flit[i*FLIT_W +: FLIT_W];
        owner_idx = PTR_W'(i);
      end
    end
  end

  // Grant of zero forces every handshake output low.
  assign out_valid = |(grant_q & in_valid);
  assign out_tail  = |(grant_q & in_tail);
  assign out_flit  = own_flit;
  assign in_ready  = grant_q & {NUM_IN{out_ready}};
  assign xfer_last = out_valid & out_ready & out_tail;

  assign grant     = grant_q;
  assign busy      = (state_q == LOCKED);
  assign cur_src   = src_q;
  assign cur_dest  = dest_q;

  // Next-state: arbitrate in IDLE, release on the owner's tail transfer.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    load_addr = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d   = LOCKED;
          grant_d   = win_gnt;
          load_addr = 1'b1;
        end
      end
      LOCKED: begin
        if (xfer_last) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_idx;
        end
      end
    endcase
  end

  // State, grant, pointer and address-latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_W'(NUM_IN - 1);
      src_q    <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (load_addr) begin
        src_q  <= win_flit[SRC_MSB:SRC_LSB];
        dest_q <= win_flit[DEST_MSB:DEST_LSB];
      end
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: queue-based upstream sources, a packet-level
// reference model checked every cycle, and directed scenario checks.
module tb_noc_output_arbiter;

  localparam int NUM_IN = 4;
  localparam int FLIT_W = 256;
  localparam int ADDR_W = 8;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_IN-1:0]        in_valid = '0;
  logic [NUM_IN*FLIT_W-1:0] in_flit = '0;
  logic [NUM_IN-1:0]        in_head = '0;
  logic [NUM_IN-1:0]        in_tail = '0;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_tail;
  logic                     out_ready = 1'b1;
  logic [NUM_IN-1:0]        grant;
  logic                     busy;
  logic [ADDR_W-1:0]        cur_src;
  logic [ADDR_W-1:0]        cur_dest;

  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;

  noc_output_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_flit(in_flit), .in_head(in_head), .in_tail(in_tail),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_tail(out_tail), .out_ready(out_ready),
    .grant(grant), .busy(busy), .cur_src(cur_src), .cur_dest(cur_dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream sources: each entry is {head, tail, flit}.
  logic [FLIT_W+1:0] srcq [NUM_IN][$];
  logic [NUM_IN-1:0] fire;

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [7:0] s, input logic [7:0] d,
                                                 input logic [15:0] tag);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[247:240] = s;
    f[239:232] = d;
    f[15:0]    = tag;
    f[100:85]  = ~tag;
    return f;
  endfunction

  task automatic push_pkt(input int port, input int len, input logic [7:0] s,
                          input logic [7:0] d, input logic [15:0] tag);
    for (int k = 0; k < len; k++) begin
      srcq[port].push_back({(k == 0), (k == len - 1), mk_flit(s, d, tag + 16'(k))});
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_IN; i++) begin
        if (fire[i] === 1'b1 && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          in_valid[i] = 1'b1;
          in_head[i]  = srcq[i][0][FLIT_W+1];
          in_tail[i]  = srcq[i][0][FLIT_W];
          in_flit[i*FLIT_W +: FLIT_W] = srcq[i][0][FLIT_W-1:0];
        end else begin
          in_valid[i] = 1'b0;
          in_head[i]  = 1'b0;
          in_tail[i]  = 1'b0;
        end
      end
    end
  end

  // Reference model: owner index (-1 idle), last owner, latched addresses.
  bit         m_on = 1'b0;
  int         m_owner, m_last, n_owner, n_last;
  logic [7:0] m_src, m_dest, n_src, n_dest;

  always @(negedge clk) begin
    if (m_on) begin
      logic [NUM_IN-1:0] e_grant, e_ready;
      logic              e_valid, e_tail;
      logic [FLIT_W-1:0] f;
      e_grant = '0; e_ready = '0; e_valid = 1'b0; e_tail = 1'b0;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        e_ready[m_owner] = out_ready;
        e_valid = in_valid[m_owner];
        e_tail  = in_tail[m_owner];
        check("m_out_flit", out_flit, in_flit[m_owner*FLIT_W +: FLIT_W]);
      end
      check("m_grant", grant, e_grant);
      check("m_busy", busy, (m_owner >= 0));
      check("m_out_valid", out_valid, e_valid);
      check("m_out_tail", out_tail, e_tail);
      check("m_in_ready", in_ready, e_ready);
      check("m_cur_src", cur_src, m_src);
      check("m_cur_dest", cur_dest, m_dest);
      if (out_valid === 1'b1 && out_ready === 1'b1) xfers++;

      n_owner = m_owner; n_last = m_last; n_src = m_src; n_dest = m_dest;
      if (m_owner < 0) begin
        for (int k = 1; k <= NUM_IN; k++) begin
          int c;
          c = (m_last + k) % NUM_IN;
          if (n_owner < 0 && in_valid[c] && in_head[c]) begin
            n_owner = c;
            f = in_flit[c*FLIT_W +: FLIT_W];
            n_src  = f[247:240];
            n_dest = f[239:232];
          end
        end
      end else if (in_valid[m_owner] && out_ready && in_tail[m_owner]) begin
        n_owner = -1;
        n_last  = m_owner;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1; m_owner = -1; m_last = NUM_IN - 1; m_src = '0; m_dest = '0;
    end else if (m_on) begin
      m_owner = n_owner; m_last = n_last; m_src = n_src; m_dest = n_dest;
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_busy(input bit want, input string name);
    int n;
    n = 0;
    while (((grant != '0) != want) && n < 50) begin
      tick();
      n++;
    end
    check(name, (grant != '0), want);
  endtask

  logic [3:0] exp_seq [15] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0,
                               4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    // Reset state
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_cur_src", cur_src, 8'h00);
    check("rst_cur_dest", cur_dest, 8'h00);

    // Inputs 0 and 2 contend: 0 first, then 2
    push_pkt(0, 2, 8'hA0, 8'hB0, 16'h0100);
    push_pkt(2, 2, 8'hA2, 8'hB2, 16'h0200);
    tick();
    check("s2_pre_arb", grant, 4'b0000);
    tick();
    check("s2_first", grant, 4'b0001);
    check("s2_src0", cur_src, 8'hA0);
    wait_busy(1'b0, "s2_release0");
    wait_busy(1'b1, "s2_regrant");
    check("s2_second", grant, 4'b0100);
    check("s2_dest2", cur_dest, 8'hB2);
    wait_busy(1'b0, "s2_release2");

    // Input 1, 3-flit packet, toggling out_ready
    xfers = 0;
    push_pkt(1, 3, 8'h12, 8'h34, 16'h1000);
    wait_busy(1'b1, "s3_grant");
    check("s3_owner", grant, 4'b0010);
    check("s3_src", cur_src, 8'h12);
    check("s3_dest", cur_dest, 8'h34);
    for (int n = 0; n < 40 && grant != '0; n++) begin
      out_ready = ~out_ready;
      #1;
      check("s3_others_ready", in_ready & 4'b1101, 4'b0000);
      tick();
    end
    out_ready = 1'b1;
    check("s3_xfers", xfers, 3);
    check("s3_released", grant, 4'b0000);

    // Fresh reset, then all inputs send 1-flit packets continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM_IN; p++)
        push_pkt(p, 1, 8'(8'h40 + p), 8'(8'h50 + r), 16'(16'h3000 + 16*r + p));
    tick();
    for (int k = 0; k < 15; k++) begin
      tick();
      check("s4_rotate", grant, exp_seq[k]);
    end
    wait_busy(1'b0, "s4_drain");

    // Body-only flit on input 3 while idle is ignored
    srcq[3].push_back({1'b0, 1'b0, mk_flit(8'h77, 8'h88, 16'h4000)});
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s5_no_grant", grant, 4'b0000);
      check("s5_ready3", in_ready[3], 1'b0);
    end
    srcq[3].delete();
    tick(); tick();

    // Reset mid-packet on input 2, then input 0 regains top priority
    push_pkt(0, 1, 8'h60, 8'h61, 16'h5000);
    wait_busy(1'b1, "s6_g0");
    check("s6_owner0", grant, 4'b0001);
    wait_busy(1'b0, "s6_rel0");
    push_pkt(2, 3, 8'h62, 8'h63, 16'h5100);
    wait_busy(1'b1, "s6_g2");
    check("s6_owner2", grant, 4'b0100);
    tick();
    reset = 1'b1;
    srcq[2].delete();
    tick();
    check("s6_abort_grant", grant, 4'b0000);
    check("s6_abort_busy", busy, 1'b0);
    check("s6_abort_valid", out_valid, 1'b0);
    check("s6_abort_src", cur_src, 8'h00);
    reset = 1'b0;
    push_pkt(1, 1, 8'h71, 8'h72, 16'h6100);
    push_pkt(0, 1, 8'h70, 8'h73, 16'h6000);
    wait_busy(1'b1, "s6_rearb");
    check("s6_favour0", grant, 4'b0001);
    check("s6_src_after", cur_src, 8'h70);
    wait_busy(1'b0, "s6_rel_a");
    wait_busy(1'b1, "s6_next");
    check("s6_then1", grant, 4'b0010);
    wait_busy(1'b0, "s6_rel_b");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
